// File: rtl/ahb_params_pkg.sv
// Shared AHB encodings, arbiter FSM states and the burst-length helper
// used by the round-robin bus arbiter.
package ahb_params_pkg;

    localparam int NO_OF_MASTERS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        ARB   = 2'b00,
        BURST = 2'b01,
        LOCK  = 2'b10
    } arb_state_e;

    // Beats remaining after the NONSEQ beat; undefined-length bursts count as one beat.
    function automatic logic [4:0] burst_len(input hburst_e b);
        case (b)
            WRAP4, INCR4:   burst_len = 5'd3;
            WRAP8, INCR8:   burst_len = 5'd7;
            WRAP16, INCR16: burst_len = 5'd15;
            default:        burst_len = 5'd0;
        endcase
    endfunction

    function automatic logic burst_fixed(input hburst_e b);
        return (b != SINGLE) && (b != INCR);
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Rotating-priority picker: first requester after 'last' (mod N, wrapping)
// wins; 'last' itself is searched last so it only wins when it is alone.
module ahb_rr_pick
    import ahb_params_pkg::*;
#(
    parameter int N  = ahb_params_pkg::NO_OF_MASTERS,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);

    localparam int unsigned NU = N;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        s = (s >= NU) ? (s - NU) : s;
        return IW'(s);
    endfunction

    // Walk offsets 1..N from the last owner; the first hit claims the grant.
    always_comb begin
        logic          found;
        logic          hit;
        logic [IW-1:0] idx;
        found = 1'b0;
        hit   = 1'b0;
        idx   = '0;
        gnt_o = '0;
        for (int k = 1; k <= N; k++) begin
            idx        = wrap_idx(last_i, k);
            hit        = ~found & req_i[idx];
            gnt_o[idx] = gnt_o[idx] | hit;
            found      = found | hit;
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with burst/lock grant holding and split masking.
// Split masking is compiled in only when AHB_ARB_SPLIT_EN is defined.
module ahb_arbiter
    import ahb_params_pkg::*;
#(
    parameter int NO_OF_MASTERS  = ahb_params_pkg::NO_OF_MASTERS,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [NO_OF_MASTERS-1:0]         HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0]         HLOCK,
    input  logic [1:0]                       HTRANS,
    input  logic [2:0]                       HBURST,
    input  logic                             HREADY,
    input  logic [1:0]                       HRESP,
    input  logic [NO_OF_MASTERS-1:0]         HSPLIT,
    output logic [NO_OF_MASTERS-1:0]         HGRANT,
    output logic [$clog2(NO_OF_MASTERS)-1:0] HMASTER,
    output logic                             HMASTLOCK
);

    localparam int N  = NO_OF_MASTERS;
    localparam int IW = $clog2(N);
    localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  DEF_GNT  = ONE_HOT0 << DEFAULT_MASTER;
    localparam logic [IW-1:0] DEF_IDX  = IW'(DEFAULT_MASTER);

    function automatic logic [IW-1:0] onehot_idx(input logic [N-1:0] g);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = idx | (IW'(i) & {IW{g[i]}});
        end
        return idx;
    endfunction

    logic [N-1:0]  hgrant_q, hgrant_d;
    logic [IW-1:0] hmaster_q, hmaster_d;
    logic          hmastlock_q, hmastlock_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [N-1:0]  split_mask_q, split_mask_d;
    arb_state_e    state_q, state_d;

    htrans_e       trans_s;
    hburst_e       burst_s;
    hresp_e        resp_s;
    logic [IW-1:0] gidx_s;
    logic [N-1:0]  cand_s, pick_gnt_s;
    logic          pick_valid_s;
    logic          nonseq_acc_s, seq_acc_s, early_term_s, lock_req_s, split_drops_lock_s;

    assign trans_s      = htrans_e'(HTRANS);
    assign burst_s      = hburst_e'(HBURST);
    assign resp_s       = hresp_e'(HRESP);
    assign gidx_s       = onehot_idx(hgrant_q);
    assign cand_s       = HBUSREQ & ~split_mask_q;
    assign nonseq_acc_s = HREADY && (trans_s == NONSEQ);
    assign seq_acc_s    = HREADY && (trans_s == SEQ);
    assign early_term_s = !HREADY && (resp_s != OKAY);
    assign lock_req_s   = HLOCK[gidx_s] && HBUSREQ[gidx_s];

`ifdef AHB_ARB_SPLIT_EN
    assign split_drops_lock_s = (resp_s == SPLIT);
`else
    logic unused_hsplit_s;
    assign split_drops_lock_s = 1'b0;
    assign unused_hsplit_s    = ^HSPLIT;
`endif

    ahb_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req_i   (cand_s),
        .last_i  (hmaster_q),
        .gnt_o   (pick_gnt_s),
        .valid_o (pick_valid_s)
    );

    // Next-state logic for FSM, beat counter, split mask and bus outputs.
    always_comb begin
        if (early_term_s) begin
            cnt_d = 5'd0;
        end else if (nonseq_acc_s) begin
            cnt_d = burst_len(burst_s);
        end else if (seq_acc_s && (cnt_q != 5'd0)) begin
            cnt_d = cnt_q - 5'd1;
        end else begin
            cnt_d = cnt_q;
        end

        state_d = state_q;
        case (state_q)
            ARB: begin
                if (lock_req_s) begin
                    state_d = LOCK;
                end else if (nonseq_acc_s && burst_fixed(burst_s)) begin
                    state_d = BURST;
                end else begin
                    state_d = ARB;
                end
            end
            // Leave on the last beat's address so the next grant lines up with it.
            BURST: begin
                if ((seq_acc_s && (cnt_q == 5'd1)) || (cnt_q == 5'd0)) begin
                    state_d = ARB;
                end else begin
                    state_d = BURST;
                end
            end
            LOCK: begin
                if (!HLOCK[gidx_s] || !HBUSREQ[gidx_s]) begin
                    state_d = ARB;
                end else begin
                    state_d = LOCK;
                end
            end
            default: state_d = ARB;
        endcase

        if (early_term_s) begin
            if ((state_q == LOCK) && !split_drops_lock_s) begin
                state_d = LOCK;
            end else begin
                state_d = ARB;
            end
        end else begin
            state_d = state_d;
        end

        if (state_d == ARB) begin
            hgrant_d = pick_valid_s ? pick_gnt_s : DEF_GNT;
        end else begin
            hgrant_d = hgrant_q;
        end

        if (HREADY) begin
            hmaster_d   = gidx_s;
            hmastlock_d = HLOCK[gidx_s];
        end else begin
            hmaster_d   = hmaster_q;
            hmastlock_d = hmastlock_q;
        end

`ifdef AHB_ARB_SPLIT_EN
        // A clearing HSPLIT beats a simultaneous set for the same master.
        split_mask_d = (split_mask_q
                        | (((HREADY && (resp_s == SPLIT)) ? ONE_HOT0 : {N{1'b0}}) << hmaster_q))
                       & ~HSPLIT;
`else
        split_mask_d = '0;
`endif
    end

    // Arbiter state registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hgrant_q     <= DEF_GNT;
            hmaster_q    <= DEF_IDX;
            hmastlock_q  <= 1'b0;
            cnt_q        <= 5'd0;
            split_mask_q <= '0;
            state_q      <= ARB;
        end else begin
            hgrant_q     <= hgrant_d;
            hmaster_q    <= hmaster_d;
            hmastlock_q  <= hmastlock_d;
            cnt_q        <= cnt_d;
            split_mask_q <= split_mask_d;
            state_q      <= state_d;
        end
    end

    assign HGRANT    = hgrant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule
